// File: rtl/conv_pkg.sv
// Shared types and constants for the fixed-point to bf16 converter.
package conv_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } conv_state_e;

  localparam logic [15:0] BF16_NAN  = 16'h7FC0;
  localparam logic [15:0] BF16_INF  = 16'h7F80;
  localparam logic [7:0]  E8M0_BIAS = 8'd127;

endpackage

// File: rtl/conv_inttobf16.sv
// Combinational signed integer to bf16 conversion, round-to-nearest-even.
module conv_inttobf16 #(
  parameter int unsigned bit_width = 21
) (
  input  logic [bit_width-1:0] i_int,
  output logic [15:0]          o_bf16
);

  // Normalised magnitude is padded so guard/sticky bits exist for any width.
  localparam int unsigned NW = bit_width + 9;

  logic                 sign;
  logic [bit_width-1:0] mag;
  logic [7:0]           msb;
  logic [NW-1:0]        norm;
  logic                 guard;
  logic                 sticky;
  logic                 lsb;
  logic [8:0]           rnd;
  logic [7:0]           expo;

  // Magnitude, leading-one search, normalise and round.
  always_comb begin
    sign = i_int[bit_width-1];
    mag  = sign ? (~i_int + 1'b1) : i_int;
    msb  = '0;
    for (int i = 0; i < int'(bit_width); i++) begin
      if (mag[i]) msb = 8'(i);
    end
    norm   = {mag, 9'b0} << (8'(bit_width - 1) - msb);
    lsb    = norm[NW-8];
    guard  = norm[NW-9];
    sticky = |norm[NW-10:0];
    // Carry out of the 8-bit significand bumps the exponent; mantissa is then 0.
    rnd    = {1'b0, norm[NW-1 -: 8]} + 9'(guard & (sticky | lsb));
    expo   = 8'd127 + msb + 8'(rnd[8]);
    o_bf16 = (mag == '0) ? 16'h0000 : {sign, expo, rnd[6:0]};
  end

endmodule

// File: rtl/conv_fitobf16_seq.sv
// Sequential MX-block converter: latches a block of fixed-point elements and
// streams them out one per cycle as bf16 scaled by a shared E8M0 exponent.
module conv_fitobf16_seq
  import conv_pkg::*;
#(
  parameter int unsigned bit_width = 21,
  parameter int unsigned n_elem    = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [n_elem*bit_width-1:0]   i_elems,
  input  logic [7:0]                    i_scale,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [15:0]                   o_bf16,
  output logic [$clog2(n_elem)-1:0]     o_idx,
  output logic                          o_last
);

  localparam int unsigned       IW   = $clog2(n_elem);
  localparam logic [IW-1:0]     LAST = IW'(n_elem - 1);

  conv_state_e                  state_q;
  logic [n_elem*bit_width-1:0]  elems_q;
  logic [7:0]                   scale_q;
  logic [IW-1:0]                idx_q;
  logic                         valid_q;
  logic [15:0]                  bf16_q;
  logic                         last_q;

  logic                         in_hs;
  logic                         out_hs;
  logic                         at_last;
  logic [IW-1:0]                sel_idx;
  logic [bit_width-1:0]         src;
  logic [7:0]                   scale_sel;
  logic [15:0]                  conv;
  logic signed [9:0]            exp_s;
  logic [15:0]                  res;

  assign out_hs  = valid_q & i_ready;
  assign at_last = (idx_q == LAST);
  assign o_ready = (state_q == StIdle) | (out_hs & at_last);
  assign in_hs   = i_valid & o_ready;

  assign o_valid = valid_q;
  assign o_bf16  = bf16_q;
  assign o_idx   = idx_q;
  assign o_last  = last_q;

  // A loading block converts element 0 straight from the input so it appears next cycle.
  always_comb begin
    sel_idx   = in_hs ? '0 : (at_last ? '0 : idx_q + 1'b1);
    src       = in_hs ? i_elems[bit_width-1:0] : elems_q[sel_idx * bit_width +: bit_width];
    scale_sel = in_hs ? i_scale : scale_q;
  end

  conv_inttobf16 #(
    .bit_width(bit_width)
  ) u_conv (
    .i_int (src),
    .o_bf16(conv)
  );

  // Apply the shared scale to the converted exponent with saturation and flush.
  always_comb begin
    exp_s = $signed({2'b00, conv[14:7]}) + $signed({2'b00, scale_sel})
          - $signed({2'b00, E8M0_BIAS});
    res   = 16'h0000;
    if (scale_sel == 8'hFF) begin
      res = BF16_NAN;
    end else if (conv[14:0] == '0) begin
      res = 16'h0000;
    end else if (exp_s >= 10'sd255) begin
      res = {conv[15], BF16_INF[14:0]};
    end else if (exp_s <= 10'sd0) begin
      res = {conv[15], 15'h0000};
    end else begin
      res = {conv[15], exp_s[7:0], conv[6:0]};
    end
  end

  // Sequencing FSM with registered output element.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      elems_q <= '0;
      scale_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      bf16_q  <= 16'h0000;
      last_q  <= 1'b0;
    end else begin
      if (in_hs) begin
        elems_q <= i_elems;
        scale_q <= i_scale;
      end
      unique case (state_q)
        StIdle: begin
          if (in_hs) begin
            state_q <= StRun;
            valid_q <= 1'b1;
            idx_q   <= '0;
            bf16_q  <= res;
            last_q  <= (LAST == '0);
          end
        end
        StRun: begin
          if (out_hs) begin
            if (!at_last) begin
              idx_q  <= sel_idx;
              bf16_q <= res;
              last_q <= (sel_idx == LAST);
            end else if (in_hs) begin
              idx_q  <= '0;
              bf16_q <= res;
              last_q <= (LAST == '0);
            end else begin
              state_q <= StIdle;
              valid_q <= 1'b0;
              idx_q   <= '0;
              bf16_q  <= 16'h0000;
              last_q  <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_fitobf16_seq.sv
// Randomised scoreboard bench for conv_fitobf16_seq.
module tb_conv_fitobf16_seq;

  localparam int BW = 21;
  localparam int N  = 32;

  typedef struct {
    logic [15:0] bf;
    int          idx;
    bit          last;
  } exp_t;

  logic            clk;
  logic            rst_n;
  logic            valid;
  logic            o_ready;
  logic [N*BW-1:0] elems;
  logic [7:0]      scl;
  logic            o_valid;
  logic            i_ready;
  logic [15:0]     o_bf16;
  logic [4:0]      o_idx;
  logic            o_last;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  int   blk[N];
  int   cur_vals[N];
  bit   rdy_random = 0;
  bit   stall_arm = 0;
  bit   stall_seen = 0;
  int   stall_cnt = 0;
  bit   prev_stall = 0;
  logic [15:0] prev_bf;
  logic [4:0]  prev_idx;

  conv_fitobf16_seq #(
    .bit_width(BW),
    .n_elem   (N)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_valid(valid),
    .o_ready(o_ready),
    .i_elems(elems),
    .i_scale(scl),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_bf16 (o_bf16),
    .o_idx  (o_idx),
    .o_last (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Integer to bf16 via the double-precision encoding, round-to-nearest-even.
  function automatic logic [15:0] ref_conv(input int v);
    real         r;
    logic [63:0] b;
    logic [15:0] h;
    logic [44:0] rest;
    if (v == 0) return 16'h0000;
    r    = v;
    b    = $realtobits(r);
    h    = {b[63], 8'(int'(b[62:52]) - 896), b[51:45]};
    rest = b[44:0];
    if (rest > {1'b1, 44'b0} || (rest == {1'b1, 44'b0} && b[45])) h = h + 16'd1;
    return h;
  endfunction

  function automatic logic [15:0] ref_out(input int v, input int scale);
    logic [15:0] c;
    int          e;
    if (scale == 255) return 16'h7FC0;
    c = ref_conv(v);
    if (c == 16'h0000) return 16'h0000;
    e = int'(c[14:7]) + scale - 127;
    if (e >= 255) return {c[15], 15'h7F80};
    if (e <= 0) return {c[15], 15'h0000};
    return {c[15], 8'(e), c[6:0]};
  endfunction

  // Downstream ready: optional random backpressure plus one armed 3-cycle stall at idx 5.
  always @(posedge clk) begin
    #1;
    if (stall_cnt > 0) begin
      i_ready = 1'b0;
      stall_cnt--;
    end else if (stall_arm && o_valid && o_idx == 5'd5) begin
      i_ready    = 1'b0;
      stall_cnt  = 2;
      stall_arm  = 0;
      stall_seen = 1;
    end else begin
      i_ready = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: handshake protocol, stall stability and scoreboard comparison.
  always @(negedge clk) begin
    if (rst_n) begin
      check_eq("o_valid", 32'(o_valid), 32'(q.size() != 0));
      check_eq("o_ready", 32'(o_ready), 32'(q.size() == 0 || (q.size() == 1 && i_ready)));
      if (prev_stall) begin
        check_eq("hold_bf16", 32'(o_bf16), 32'(prev_bf));
        check_eq("hold_idx", 32'(o_idx), 32'(prev_idx));
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          check_eq("extra_out", 32'(q.size()), 32'd1);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("bf16", 32'(o_bf16), 32'(e.bf));
          check_eq("idx", 32'(o_idx), 32'(e.idx));
          check_eq("last", 32'(o_last), 32'(e.last));
        end
      end
      if (valid && o_ready) begin
        for (int k = 0; k < N; k++) begin
          exp_t e;
          e.bf   = ref_out(cur_vals[k], int'(scl));
          e.idx  = k;
          e.last = (k == N - 1);
          q.push_back(e);
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_bf    = o_bf16;
      prev_idx   = o_idx;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic send_block(input int scale);
    bit done = 0;
    for (int k = 0; k < N; k++) begin
      cur_vals[k]          = blk[k];
      elems[k*BW +: BW]    = BW'(blk[k]);
    end
    scl   = 8'(scale);
    valid = 1'b1;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      if (o_ready) begin
        done = 1;
        @(posedge clk);
        #1;
      end
    end
    if (!done) check_eq("in_timeout", 32'(done), 32'd1);
    valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 5000 && q.size() != 0; c++) @(negedge clk);
    check_eq("drain", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_elem();
    unique case ($urandom_range(0, 3))
      0: return 0;
      1: return int'($urandom_range(0, 600)) - 300;
      default: return int'($urandom_range(0, (1 << BW) - 1)) - (1 << (BW - 1));
    endcase
  endfunction

  function automatic int rand_scale();
    int tbl[8] = '{0, 1, 100, 127, 128, 200, 254, 255};
    if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 7)];
    return int'($urandom_range(0, 255));
  endfunction

  task automatic fill_random();
    for (int k = 0; k < N; k++) blk[k] = rand_elem();
  endtask

  task automatic pulse_reset_checks(input string tag);
    check_eq({tag, "_valid"}, 32'(o_valid), 32'd0);
    check_eq({tag, "_ready"}, 32'(o_ready), 32'd1);
    check_eq({tag, "_bf16"}, 32'(o_bf16), 32'd0);
    check_eq({tag, "_idx"}, 32'(o_idx), 32'd0);
    check_eq({tag, "_last"}, 32'(o_last), 32'd0);
  endtask

  initial begin
    bit found = 0;
    rst_n   = 1'b0;
    valid   = 1'b0;
    elems   = '0;
    scl     = '0;
    i_ready = 1'b1;
    #2;
    pulse_reset_checks("rst");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All +1 at unity scale.
    for (int k = 0; k < N; k++) blk[k] = 1;
    send_block(127);
    drain();

    // +1/-1 at scale 128, then the same at scale 0 back-to-back.
    for (int k = 0; k < N; k++) blk[k] = (k % 2 == 0) ? 1 : -1;
    send_block(128);
    send_block(0);
    drain();

    // NaN scale on random data, then overflow to infinity.
    fill_random();
    send_block(255);
    for (int k = 0; k < N; k++) blk[k] = (1 << (BW - 1)) - 1;
    blk[1] = -((1 << (BW - 1)) - 1);
    send_block(254);
    drain();

    // Three-cycle downstream stall at idx 5.
    stall_arm = 1;
    fill_random();
    send_block(130);
    drain();
    check_eq("stall_seen", 32'(stall_seen), 32'd1);

    // Two blocks with valid held high.
    fill_random();
    send_block(120);
    fill_random();
    send_block(135);
    drain();

    // Asynchronous reset in the middle of a block.
    fill_random();
    send_block(127);
    for (int c = 0; c < 200 && !found; c++) begin
      if (o_valid && o_idx == 5'd10) found = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("reach_idx10", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    pulse_reset_checks("midrst");
    q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random();
    send_block(140);
    drain();

    // Random blocks under random backpressure.
    rdy_random = 1;
    for (int b = 0; b < 20; b++) begin
      fill_random();
      send_block(rand_scale());
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_fitobf16_seq.md
CONV_FITOBF16_SEQ -- requirements
Module: conv_fitobf16_seq

Interface
REQ-001 The block SHALL have parameter bit_width, default 21, giving the width of one signed fixed-point element.
REQ-002 The block SHALL have parameter n_elem, default 32, giving the number of elements per MX block.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_valid, input, 1 bit: input block valid.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block can accept an input block.
REQ-007 The block SHALL have port i_elems, input, n_elem*bit_width bits: element k occupies bits [k*bit_width +: bit_width].
REQ-008 The block SHALL have port i_scale, input, 8 bits: shared E8M0 scale (bias 127).
REQ-009 The block SHALL have port o_valid, output, 1 bit: output element valid.
REQ-010 The block SHALL have port i_ready, input, 1 bit: downstream accepts the output element.
REQ-011 The block SHALL have port o_bf16, output, 16 bits: the scaled bf16 result.
REQ-012 The block SHALL have port o_idx, output, clog2(n_elem) bits: element index of o_bf16.
REQ-013 The block SHALL have port o_last, output, 1 bit: high when o_idx equals n_elem-1.

Function
REQ-014 An input handshake SHALL occur when i_valid and o_ready are both high; elems and scale are latched into a block register.
REQ-015 An output handshake SHALL occur when o_valid and i_ready are both high.
REQ-016 The FSM SHALL have two states, IDLE and RUN; IDLE goes to RUN on an input handshake; RUN goes to IDLE on the output handshake of the last element with no simultaneous input handshake.
REQ-017 o_ready SHALL be high in IDLE, and in RUN only during the cycle of the last element's output handshake, giving back-to-back blocks with no bubble.
REQ-018 One shared conv_inttobf16 instance SHALL convert the element selected by the index counter; there SHALL be exactly one conversion path.
REQ-019 The result SHALL be registered: element 0 appears on o_valid one cycle after the input handshake, and the element rate SHALL be one per cycle while i_ready is high.
REQ-020 While o_valid is high and i_ready is low, o_bf16, o_idx and o_last SHALL hold stable and the counter SHALL not advance.
REQ-021 The counter SHALL advance on each output handshake and SHALL wrap to 0 after n_elem-1.
REQ-022 The scaling rules SHALL be:
- Let c be the conv_inttobf16 output, with sign s and exponent field e; compute e' = e + scale - 127 at 10-bit signed width.
- c zero: output 0x0000.
- scale 0xFF: output 0x7FC0 (NaN), for any element.
- e' >= 255: output sign s with 0x7F80 (±inf).
- e' <= 0: output sign s with zero (flush to zero, no subnormals).
- Otherwise: output {s, e'[7:0], c mantissa}.
REQ-023 An input handshake coinciding with the last output handshake SHALL load the new block, reset the counter to 0, and stay in RUN.

Reset
REQ-024 Asserting i_rst_n low SHALL immediately force IDLE, counter 0, o_valid 0, o_bf16 0x0000, o_idx 0, o_last 0, and the block register to 0, even mid-block; the remaining elements of an interrupted block SHALL be discarded.
REQ-025 o_ready SHALL be 1 while the block is in reset.
REQ-026 After reset deasserts, the first input handshake SHALL occur no earlier than the first i_clk rising edge.

Structure
REQ-027 Package conv_pkg SHALL hold the FSM state enum, BF16_NAN (0x7FC0), BF16_INF (0x7F80), and E8M0_BIAS (127).
REQ-028 The single sub-module SHALL be conv_inttobf16 with bit_width passed through; scaling and sequencing SHALL stay in conv_fitobf16_seq.

Verification
REQ-029 Block of all ones (+1), scale 127, i_ready held high -> 32 outputs 0x3F80 on consecutive cycles starting one cycle after the handshake, idx 0..31, o_last only on idx 31.
REQ-030 Elements +1 and -1 with scale 128 -> 0x4000 and 0xC000; the same elements with scale 0 -> 0x0000 and 0x8000.
REQ-031 Scale 0xFF -> every output 0x7FC0; element 2^20-1 with scale 254 -> 0x7F80.
REQ-032 i_ready low for 3 cycles at idx 5 -> o_bf16 and o_idx held for 3 cycles, then idx 6 follows; no element is lost or duplicated.
REQ-033 Two blocks presented with i_valid held high -> o_ready pulses on the idx-31 handshake, and idx 0 of block 2 follows idx 31 with zero bubble cycles.
REQ-034 i_rst_n pulsed low at idx 10 -> outputs reach their reset values asynchronously; the next block restarts at idx 0 and matches a reference model computing the C conversion plus the scaling rules.
